// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and width helpers for the fetch front-end
// Purpose: default widths, the queue entry type and small width functions
// used by instr_fetch_if, fetch_queue and instr_fetch.
package fetch_pkg;

  localparam int FETCH_AW    = 32;  // default address width
  localparam int FETCH_ISIZE = 2;   // default log2 of instruction bytes

  // Instruction width in bits for a given log2 byte size.
  function automatic int iw(input int isize);
    return 8 << isize;
  endfunction

  // Width of the outstanding/drop counters: up to 2*depth in flight after
  // back-to-back flushes.
  function automatic int cnt_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

  // One queue slot. Fields are sized for the default configuration; the
  // queue casts its port widths onto them.
  typedef struct packed {
    logic [FETCH_AW-1:0]        addr;
    logic [iw(FETCH_ISIZE)-1:0] data;
    logic                       filled;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - memory request/response and decode handshake bundle
// Purpose: groups the fetch unit's memory port and decode port.
// master: fetch side (drives requests and instructions).
// slave : memory/decode side (drives ready, responses).
interface instr_fetch_if
  import fetch_pkg::*;
#(
  parameter int bits  = FETCH_AW,
  parameter int isize = FETCH_ISIZE
);
  localparam int IW = iw(isize);

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [bits-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [IW-1:0]   mem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [IW-1:0]   inst_data;
  logic [bits-1:0] inst_addr;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output inst_valid, inst_data, inst_addr,
    input  inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  inst_valid, inst_data, inst_addr,
    output inst_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order ring of fetch entries with alloc/fill/read ports
// Purpose: alloc reserves a slot with its address, fill writes returned data
// into the oldest unfilled slot, read frees the oldest slot.
// Ports: clk, rst (async, high), i_clear (empty the ring next edge),
// i_alloc/i_alloc_addr, i_fill/i_fill_data, i_read,
// o_cnt (allocated minus consumed), o_filled/o_addr/o_data (slot at read).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int depth = 2,
  parameter int aw    = FETCH_AW,
  parameter int dw    = iw(FETCH_ISIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_alloc,
  input  logic [aw-1:0]              i_alloc_addr,
  input  logic                       i_fill,
  input  logic [dw-1:0]              i_fill_data,
  input  logic                       i_read,
  output logic [$clog2(depth+1)-1:0] o_cnt,
  output logic                       o_filled,
  output logic [aw-1:0]              o_addr,
  output logic [dw-1:0]              o_data
);
  localparam int PW = $clog2(depth);
  localparam int CQ = $clog2(depth + 1);

  fetch_entry_t  r_ent [depth];
  logic [PW-1:0] r_alloc;
  logic [PW-1:0] r_fill;
  logic [PW-1:0] r_read;
  logic [CQ-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) r_ent[i] <= '0;
      r_alloc <= '0;
      r_fill  <= '0;
      r_read  <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < depth; i++) r_ent[i] <= '0;
      r_alloc <= '0;
      r_fill  <= '0;
      r_read  <= '0;
      r_cnt   <= '0;
    end else begin
      if (i_alloc) begin
        r_ent[r_alloc].addr   <= FETCH_AW'(i_alloc_addr);
        r_ent[r_alloc].filled <= 1'b0;
        r_alloc               <= r_alloc + 1'b1;
      end
      // Placed after alloc: with a zero-latency memory the fill lands on the
      // slot being allocated in the same cycle and must win the filled bit.
      if (i_fill) begin
        r_ent[r_fill].data   <= i_fill_data;
        r_ent[r_fill].filled <= 1'b1;
        r_fill               <= r_fill + 1'b1;
      end
      if (i_read) begin
        r_ent[r_read].filled <= 1'b0;
        r_read               <= r_read + 1'b1;
      end
      r_cnt <= r_cnt + CQ'(i_alloc) - CQ'(i_read);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_filled = r_ent[r_read].filled;
  assign o_addr   = aw'(r_ent[r_read].addr);
  assign o_data   = dw'(r_ent[r_read].data);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch front-end: request credit, drop and flush
// Purpose: issues in-order reads at pc_addr, buffers returned words and hands
// them to decode; flush discards buffered and in-flight fetches.
// Ports: clk, rst (async, high), pc_addr (current pointer), pc_incr (request
// accepted), flush (redirect, same cycle as the pointer jump),
// bus (master: memory request/response and decode handshake).
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int bits  = FETCH_AW,
  parameter int isize = FETCH_ISIZE,
  parameter int depth = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] pc_addr,
  output logic            pc_incr,
  input  logic            flush,
  instr_fetch_if.master   bus
);
  localparam int IW = iw(isize);
  localparam int CW = cnt_w(depth);
  localparam int CQ = $clog2(depth + 1);

  logic [CQ-1:0] w_cnt;
  logic          w_filled;
  logic          w_fire;
  logic          w_deliver;
  logic          w_rsp_ok;
  logic          w_fill;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;

  // Credit uses only the registered count, so a delivery never frees a slot
  // for a request in the same cycle.
  assign bus.mem_req_valid = !rst && !flush && (w_cnt < CQ'(depth));
  assign bus.mem_req_addr  = pc_addr;
  assign w_fire            = bus.mem_req_valid && bus.mem_req_ready;
  assign pc_incr           = w_fire;

  assign bus.inst_valid = !flush && w_filled;
  assign w_deliver      = bus.inst_valid && bus.inst_ready;

  // A response with nothing outstanding is ignored; a zero-latency response
  // to the request being accepted this cycle counts as outstanding.
  assign w_rsp_ok = bus.mem_rsp_valid && ((r_out != '0) || w_fire);
  assign w_fill   = w_rsp_ok && (r_drop == '0) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= '0;
      r_drop <= '0;
    end else if (flush) begin
      // Every fetch still in flight after this cycle is stale.
      r_out  <= r_out - CW'(w_rsp_ok);
      r_drop <= r_out - CW'(w_rsp_ok);
    end else begin
      r_out <= r_out + CW'(w_fire) - CW'(w_rsp_ok);
      if (w_rsp_ok && (r_drop != '0)) r_drop <= r_drop - CW'(1);
    end
  end

  fetch_queue #(
    .depth (depth),
    .aw    (bits),
    .dw    (IW)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (flush),
    .i_alloc      (w_fire),
    .i_alloc_addr (pc_addr),
    .i_fill       (w_fill),
    .i_fill_data  (bus.mem_rsp_data),
    .i_read       (w_deliver),
    .o_cnt        (w_cnt),
    .o_filled     (w_filled),
    .o_addr       (bus.inst_addr),
    .o_data       (bus.inst_data)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] pc_addr = 32'h100;
  logic        pc_incr;

  instr_fetch_if #(.bits(32), .isize(2)) bus ();

  instr_fetch #(.bits(32), .isize(2), .depth(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .pc_addr (pc_addr),
    .pc_incr (pc_incr),
    .flush   (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          ret;
  } live_t;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  live_t       live[$];   // fetches since the last flush, oldest first
  pend_t       pend[$];   // memory's pending responses, in order
  logic [31:0] dlog[$];   // delivered addresses (observed)
  logic [31:0] flog[$];   // requested addresses (observed)
  int          out_m, drop_m, cyc, lat;
  bit          rnd_rsp;
  logic [31:0] pc_m;
  int          tests, fails;
  bit          last_incr, last_iv;
  logic [31:0] last_req_addr, last_inst_addr;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, update it.
  task automatic step(input bit fl, input logic [31:0] target);
    bit          exp_req, exp_iv, mf, rsp, imm, dlv;
    logic [31:0] req_addr;
    live_t       e;
    flush   = fl;
    pc_addr = pc_m;
    rsp = (pend.size() > 0) && (pend[0].due <= cyc) &&
          (!rnd_rsp || ($urandom_range(0, 3) != 0));
    bus.mem_rsp_valid = rsp;
    bus.mem_rsp_data  = rsp ? fdata(pend[0].addr) : 32'h0;
    #1;
    exp_req  = !fl && (live.size() < DEPTH);
    exp_iv   = !fl && (live.size() > 0) && live[0].ret;
    mf       = exp_req && bus.mem_req_ready;
    req_addr = bus.mem_req_addr;
    imm      = 1'b0;
    if (lat == 0 && mf && pend.size() == 0 && (!rnd_rsp || $urandom_range(0, 1) == 1)) begin
      imm = 1'b1;
      rsp = 1'b1;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = fdata(pc_m);
      #1;
    end
    tests++;
    if (bus.mem_req_valid !== exp_req) begin
      fails++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, bus.mem_req_valid, exp_req);
    end
    tests++;
    if (pc_incr !== mf) begin
      fails++;
      $display("FAIL pc_incr cyc=%0d got=%b exp=%b", cyc, pc_incr, mf);
    end
    tests++;
    if (bus.mem_req_addr !== pc_m) begin
      fails++;
      $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_req_addr, pc_m);
    end
    tests++;
    if (bus.inst_valid !== exp_iv) begin
      fails++;
      $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, bus.inst_valid, exp_iv);
    end
    if (exp_iv) begin
      tests++;
      if (bus.inst_addr !== live[0].addr) begin
        fails++;
        $display("FAIL inst_addr cyc=%0d got=%h exp=%h", cyc, bus.inst_addr, live[0].addr);
      end
      tests++;
      if (bus.inst_data !== fdata(live[0].addr)) begin
        fails++;
        $display("FAIL inst_data cyc=%0d got=%h exp=%h", cyc, bus.inst_data, fdata(live[0].addr));
      end
    end
    if (rsp && out_m == 0 && !mf) begin
      fails++;
      $display("FAIL protocol cyc=%0d response with nothing outstanding", cyc);
    end
    dlv            = exp_iv && bus.inst_ready;
    last_incr      = pc_incr;
    last_req_addr  = req_addr;
    last_iv        = bus.inst_valid;
    last_inst_addr = bus.inst_addr;
    if (bus.inst_valid && bus.inst_ready) dlog.push_back(bus.inst_addr);
    if (pc_incr) flog.push_back(req_addr);
    if (rsp && !imm) void'(pend.pop_front());
    if (mf && !imm) pend.push_back('{addr: pc_m, due: cyc + ((lat < 1) ? 1 : lat)});
    if (fl) begin
      drop_m = out_m - int'(rsp);
      out_m  = drop_m;
      live.delete();
      pc_m = target;
    end else begin
      if (dlv) void'(live.pop_front());
      if (mf) begin
        live.push_back('{addr: pc_m, ret: 1'b0});
        out_m++;
        pc_m += 32'd4;
      end
      if (rsp) begin
        if (drop_m > 0) drop_m--;
        else begin
          for (int i = 0; i < live.size(); i++) begin
            if (!live[i].ret) begin
              e = live[i];
              e.ret = 1'b1;
              live[i] = e;
              break;
            end
          end
        end
        out_m--;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    rst = 1'b1;
    flush = 1'b0;
    pc_m = pc;
    pc_addr = pc;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = 32'h0;
    pend.delete();
    live.delete();
    dlog.delete();
    flog.delete();
    out_m = 0;
    drop_m = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pc_addr = 32'h100;
    repeat (3) begin
      @(posedge clk);
      #2;
      tests++;
      if (bus.mem_req_valid !== 1'b0 || pc_incr !== 1'b0) begin
        fails++;
        $display("FAIL reset_req got=%b/%b exp=0/0", bus.mem_req_valid, pc_incr);
      end
      tests++;
      if (bus.inst_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_inst_valid got=%b exp=0", bus.inst_valid);
      end
      tests++;
      if (bus.inst_addr !== 32'h0 || bus.inst_data !== 32'h0) begin
        fails++;
        $display("FAIL reset_inst got=%h/%h exp=0/0", bus.inst_addr, bus.inst_data);
      end
    end
    rst = 1'b0;
    #1;
    tests++;
    if (bus.mem_req_valid !== 1'b1) begin
      fails++;
      $display("FAIL release_req_valid got=%b exp=1", bus.mem_req_valid);
    end
    tests++;
    if (bus.mem_req_addr !== 32'h100) begin
      fails++;
      $display("FAIL release_req_addr got=%h exp=00000100", bus.mem_req_addr);
    end
  endtask

  task automatic test_streaming();
    lat = 0; rnd_rsp = 0;
    bus.mem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    do_reset(32'h0);
    repeat (20) step(1'b0, 32'h0);
    tests++;
    if (dlog.size() != 19) begin
      fails++;
      $display("FAIL stream_count got=%0d exp=19", dlog.size());
    end
    for (int i = 0; i < dlog.size(); i++) begin
      tests++;
      if (dlog[i] !== 32'(4 * i)) begin
        fails++;
        $display("FAIL stream_addr idx=%0d got=%h exp=%h", i, dlog[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    lat = 1; rnd_rsp = 0;
    bus.mem_req_ready = 1'b1; bus.inst_ready = 1'b0;
    do_reset(32'h0);
    repeat (5) step(1'b0, 32'h0);
    tests++;
    if (flog.size() != 2 || flog[0] !== 32'h0 || flog[1] !== 32'h4) begin
      fails++;
      $display("FAIL bp_requests got_count=%0d exp=2 (0x0,0x4)", flog.size());
    end
    tests++;
    if (bus.mem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_stall got=%b exp=0", bus.mem_req_valid);
    end
    bus.inst_ready = 1'b1;
    step(1'b0, 32'h0);
    tests++;
    if (last_iv !== 1'b1 || last_inst_addr !== 32'h0 || last_incr !== 1'b0) begin
      fails++;
      $display("FAIL bp_release got iv=%b addr=%h incr=%b exp 1/0/0", last_iv, last_inst_addr, last_incr);
    end
    step(1'b0, 32'h0);
    tests++;
    if (last_incr !== 1'b1 || last_req_addr !== 32'h8) begin
      fails++;
      $display("FAIL bp_next_req got incr=%b addr=%h exp 1/00000008", last_incr, last_req_addr);
    end
  endtask

  task automatic test_flush_inflight();
    int n;
    lat = 4; rnd_rsp = 0;
    bus.mem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    do_reset(32'h0);
    n = 0;
    while (!(pend.size() == 2 && pend[0].addr == 32'h8 && pend[1].addr == 32'hC) && n < 30) begin
      step(1'b0, 32'h0);
      n++;
    end
    tests++;
    if (n >= 30) begin
      fails++;
      $display("FAIL flush2_setup timeout got=%0d pending exp=2", pend.size());
    end
    dlog.delete(); flog.delete();
    step(1'b1, 32'h40);
    tests++;
    if (dut.r_drop !== 3'd2) begin
      fails++;
      $display("FAIL flush2_drop got=%0d exp=2", dut.r_drop);
    end
    n = 0;
    while (dlog.size() == 0 && n < 30) begin
      step(1'b0, 32'h0);
      n++;
    end
    tests++;
    if (dlog.size() == 0 || dlog[0] !== 32'h40) begin
      fails++;
      $display("FAIL flush2_first_inst got_count=%0d exp first addr 00000040", dlog.size());
    end
    tests++;
    if (flog.size() == 0 || flog[0] !== 32'h40) begin
      fails++;
      $display("FAIL flush2_first_req got_count=%0d exp first addr 00000040", flog.size());
    end
  endtask

  task automatic test_flush_with_rsp();
    int n;
    lat = 2; rnd_rsp = 0;
    bus.mem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    do_reset(32'h0);
    step(1'b0, 32'h0);
    bus.mem_req_ready = 1'b0;
    step(1'b0, 32'h0);
    dlog.delete();
    step(1'b1, 32'h80);
    tests++;
    if (dut.r_drop !== 3'd0 || dut.r_out !== 3'd0) begin
      fails++;
      $display("FAIL flushrsp_counters got drop=%0d out=%0d exp 0/0", dut.r_drop, dut.r_out);
    end
    bus.mem_req_ready = 1'b1;
    n = 0;
    while (dlog.size() == 0 && n < 20) begin
      step(1'b0, 32'h0);
      n++;
    end
    tests++;
    if (dlog.size() == 0 || dlog[0] !== 32'h80) begin
      fails++;
      $display("FAIL flushrsp_first_inst got_count=%0d exp first addr 00000080", dlog.size());
    end
  endtask

  task automatic test_async_reset();
    lat = 0; rnd_rsp = 0;
    bus.mem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    do_reset(32'h0);
    repeat (6) step(1'b0, 32'h0);
    flush = 1'b0; pc_addr = pc_m; bus.mem_rsp_valid = 1'b0;
    #1;
    tests++;
    if (bus.inst_valid !== 1'b1) begin
      fails++;
      $display("FAIL areset_pre inst_valid got=%b exp=1", bus.inst_valid);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (bus.inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL areset_inst_valid got=%b exp=0", bus.inst_valid);
    end
    tests++;
    if (pc_incr !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL areset_req got incr=%b valid=%b exp 0/0", pc_incr, bus.mem_req_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (pc_incr !== 1'b0) begin
      fails++;
      $display("FAIL areset_hold pc_incr got=%b exp=0", pc_incr);
    end
    do_reset(32'h200);
    repeat (4) step(1'b0, 32'h0);
    tests++;
    if (dlog.size() == 0 || dlog[0] !== 32'h200) begin
      fails++;
      $display("FAIL areset_recover got_count=%0d exp first addr 00000200", dlog.size());
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 4; seg++) begin
      lat = seg; rnd_rsp = 1;
      do_reset($urandom & 32'hFFFF_FFFC);
      repeat (200) begin
        bus.mem_req_ready = ($urandom_range(0, 3) != 0);
        bus.inst_ready    = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) step(1'b1, $urandom & 32'hFFFF_FFFC);
        else step(1'b0, 32'h0);
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; lat = 0; rnd_rsp = 0;
    out_m = 0; drop_m = 0; pc_m = 32'h100;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'h0;
    bus.inst_ready    = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_inflight();
    test_flush_with_rsp();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
